// File: rtl/freq_meas_sequencer_if.sv
// Byte-stream link from the measurement sequencer to the UART transmitter.
//
// Signals:
//   tx_data  [7:0]  byte being offered
//   tx_valid        the sequencer has a byte on tx_data
//   tx_ready        the transmitter can take a byte this cycle
//
// Handshake: a byte moves on a clock edge where tx_valid && tx_ready. Once
// tx_valid is raised it stays high, and tx_data stays unchanged, until that
// transfer happens. tx_ready may toggle freely and has no effect while
// tx_valid is low.
//
// Modports: master = sequencer side, slave = transmitter side.
interface freq_meas_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/freq_meas_sequencer.sv
// Frequency measurement sequencer.
//
// Opens a gate window on the external counter block, waits for the error
// registers to settle, then streams one frame over the byte link:
//   0xA5, then for each channel its error word zero-extended to 32 bits and
//   sent MSB first, then (optional) an XOR checksum of all data bytes.
//
// Optional feature macro: FRAME_CHECKSUM_EN
//   defined   -> a CSUM state appends the XOR of all data bytes (header excluded)
//   undefined -> no checksum logic; the frame ends after the last data byte
//
// Ports:
//   clk_ocxo    reference clock (only clock)
//   rst         synchronous active-high reset
//   start       one-cycle pulse, accepted only while idle
//   cont        level; re-arm the gate automatically after each frame
//   gate_cnt    reference count from the counter block
//   meas_en     enable to the counter block
//   ch_sel      channel index to the external combinational error mux
//   ch_data     selected error word, valid in the same cycle as ch_sel
//   tx          byte stream to the UART transmitter (master side)
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse at the end of each frame
//   state_dbg   current state encoding for observation
module freq_meas_sequencer #(
    parameter int BIT_CNT       = 29,
    parameter int NUM_CH        = 15,
    parameter int GATE_CYCLES   = 10000000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                          clk_ocxo,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          cont,
    input  logic [BIT_CNT-1:0]            gate_cnt,
    output logic                          meas_en,
    output logic [3:0]                    ch_sel,
    input  logic [BIT_CNT-1:0]            ch_data,
    freq_meas_sequencer_if.master         tx,
    output logic                          busy,
    output logic                          frame_done,
    output logic [2:0]                    state_dbg
);

    localparam int         SW         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_CH    = 4'(NUM_CH - 1);
    localparam logic [7:0] HDR_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATE   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_HDR    = 3'd3,
        ST_LOAD   = 3'd4,
        ST_SEND   = 3'd5,
`ifdef FRAME_CHECKSUM_EN
        ST_CSUM   = 3'd6,
`endif
        ST_DONE   = 3'd7
    } state_t;

    state_t        state_q,  state_d;
    logic [3:0]    ch_sel_q, ch_sel_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [1:0]    byte_q,   byte_d;
    logic [31:0]   shift_q,  shift_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]    csum_q,   csum_d;
`endif

    always_ff @(posedge clk_ocxo) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_sel_q <= '0;
            settle_q <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ch_sel_q <= ch_sel_d;
            settle_q <= settle_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_sel_d    = ch_sel_q;
        settle_d    = settle_q;
        byte_d      = byte_q;
        shift_d     = shift_q;
`ifdef FRAME_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        meas_en     = 1'b1;
        busy        = 1'b1;
        frame_done  = 1'b0;
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                meas_en = 1'b0;
                busy    = 1'b0;
                if (start) state_d = ST_GATE;
            end
            ST_GATE: begin
                // Exact match only: an overshooting count parks us here until
                // rst or an externally forced meas_en cycle.
                settle_d = '0;
                if (gate_cnt == BIT_CNT'(GATE_CYCLES)) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = ST_HDR;
                else                         settle_d = settle_q + SW'(1);
            end
            ST_HDR: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = HDR_BYTE;
`ifdef FRAME_CHECKSUM_EN
                csum_d      = '0;
`endif
                if (tx.tx_ready) begin
                    ch_sel_d = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // ch_data follows ch_sel combinationally, so it is valid now.
                shift_d = 32'(ch_data);
                byte_d  = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = shift_q[31:24];
                if (tx.tx_ready) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    byte_d  = byte_q + 2'd1;
`ifdef FRAME_CHECKSUM_EN
                    csum_d  = csum_q ^ shift_q[31:24];
`endif
                    if (byte_q == 2'd3) begin
                        if (ch_sel_q < LAST_CH) begin
                            ch_sel_d = ch_sel_q + 4'd1;
                            state_d  = ST_LOAD;
                        end else begin
`ifdef FRAME_CHECKSUM_EN
                            state_d  = ST_CSUM;
`else
                            state_d  = ST_DONE;
`endif
                        end
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CSUM: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = csum_q;
                if (tx.tx_ready) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                // meas_en drops for this single cycle so the counter restarts.
                meas_en    = 1'b0;
                frame_done = 1'b1;
                state_d    = cont ? ST_GATE : ST_IDLE;
            end
            default: begin
                meas_en = 1'b0;
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ch_sel    = ch_sel_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
module tb_freq_meas_sequencer;
    localparam int BIT_CNT       = 29;
    localparam int NUM_CH        = 3;
    localparam int GATE_CYCLES   = 100;
    localparam int SETTLE_CYCLES = 4;
`ifdef FRAME_CHECKSUM_EN
    localparam int FRAME_BYTES   = 2 + 4 * NUM_CH;
`else
    localparam int FRAME_BYTES   = 1 + 4 * NUM_CH;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               cont = 1'b0;
    logic               tx_ready = 1'b1;
    logic               rand_ready = 1'b0;
    logic [BIT_CNT-1:0] gate_cnt;
    logic [BIT_CNT-1:0] ch_data;
    logic               meas_en;
    logic [3:0]         ch_sel;
    logic               busy;
    logic               frame_done;
    logic [2:0]         state_dbg;
    logic [BIT_CNT-1:0] ch_val [NUM_CH];

    freq_meas_sequencer_if tx_bus ();
    assign tx_bus.tx_ready = tx_ready;

    freq_meas_sequencer #(
        .BIT_CNT(BIT_CNT), .NUM_CH(NUM_CH),
        .GATE_CYCLES(GATE_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk_ocxo(clk), .rst(rst), .start(start), .cont(cont),
        .gate_cnt(gate_cnt), .meas_en(meas_en), .ch_sel(ch_sel),
        .ch_data(ch_data), .tx(tx_bus), .busy(busy),
        .frame_done(frame_done), .state_dbg(state_dbg)
    );

    // ---------------- clock / environment ----------------
    always #5 clk = ~clk;

    // Counter block: free-runs while enabled, restarts when meas_en drops.
    always @(posedge clk) begin
        if (rst) gate_cnt <= '0;
        else     gate_cnt <= meas_en ? gate_cnt + 1'b1 : '0;
    end

    // Combinational error mux.
    always_comb begin
        ch_data = '0;
        if (int'(ch_sel) < NUM_CH) ch_data = ch_val[int'(ch_sel)];
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];
    int done_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one frame built from the channel values.
    task automatic push_frame();
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        exp_q.push_back(8'hA5);
        for (int c = 0; c < NUM_CH; c++) begin
            w = 32'(ch_val[c]);
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(w[8*b +: 8]);
                x ^= w[8*b +: 8];
            end
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // ---------------- per-cycle compare process ----------------
    int         cyc = 0;
    int         hit_cyc = -1;
    logic       awaiting = 1'b0;
    logic       prev_rst = 1'b1, prev_meas = 1'b0, prev_done = 1'b0, prev_cont = 1'b0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            awaiting = 1'b0;
            hit_cyc  = -1;
        end else begin
            if (prev_rst) begin
                check("post_rst_meas_en",  meas_en, 0);
                check("post_rst_tx_valid", tx_bus.tx_valid, 0);
                check("post_rst_tx_data",  tx_bus.tx_data, 0);
                check("post_rst_busy",     busy, 0);
                check("post_rst_ch_sel",   ch_sel, 0);
                check("post_rst_done",     frame_done, 0);
            end
            check("meas_en_rule", meas_en, busy && !frame_done);
            if (meas_en && !prev_meas) begin
                push_frame();
                awaiting = 1'b1;
                hit_cyc  = -1;
            end
            if (awaiting && meas_en && gate_cnt == BIT_CNT'(GATE_CYCLES)) hit_cyc = cyc;
            if (awaiting && tx_bus.tx_valid) begin
                check("settle_latency", cyc - hit_cyc, SETTLE_CYCLES + 1);
                awaiting = 1'b0;
            end
            if (prev_done) begin
                if (prev_cont) begin
                    check("cont_rearm_meas_en", meas_en, 1);
                    check("cont_rearm_busy", busy, 1);
                end else begin
                    check("idle_after_done", busy, 0);
                end
            end
            if (prev_valid && !prev_ready && !prev_rst) begin
                check("stall_valid", tx_bus.tx_valid, 1);
                check("stall_data", tx_bus.tx_data, prev_data);
            end
            if (tx_bus.tx_valid && tx_ready) begin
                rx_q.push_back(tx_bus.tx_data);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_byte: got %0h expected none at %0t", tx_bus.tx_data, $time);
                end else begin
                    check("tx_byte", tx_bus.tx_data, exp_q.pop_front());
                end
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_complete", exp_q.size(), 0);
            end
        end
        prev_rst   = rst;
        prev_meas  = meas_en;
        prev_done  = frame_done;
        prev_cont  = cont;
        prev_valid = tx_bus.tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_bus.tx_data;
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!frame_done && n < budget) begin
            tick(1);
            n++;
        end
        if (!frame_done) begin
            total++;
            bad++;
            $display("FAIL %s: timeout got no frame_done expected one", name);
        end
        tick(1);
    endtask

    task automatic wait_rx(input int cnt, input int budget, input string name);
        int n;
        n = 0;
        while (rx_q.size() < cnt && n < budget) begin
            tick(1);
            n++;
        end
        check(name, rx_q.size(), cnt);
    endtask

    task automatic set_directed();
        ch_val[0] = 29'h00000012;
        ch_val[1] = 29'h1FFFFFFF;
        ch_val[2] = 29'h00000000;
    endtask

    // ---------------- main sequence ----------------
    int d0;

    initial begin
        for (int c = 0; c < NUM_CH; c++) ch_val[c] = '0;

        // Reset held three cycles, with a start pulse inside it.
        rst = 1'b1;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        check("rst_meas_en",  meas_en, 0);
        check("rst_tx_valid", tx_bus.tx_valid, 0);
        check("rst_tx_data",  tx_bus.tx_data, 0);
        check("rst_busy",     busy, 0);
        check("rst_done",     frame_done, 0);
        check("rst_ch_sel",   ch_sel, 0);
        rst = 1'b0;
        tick(3);
        check("start_in_rst_ignored", busy, 0);

        // Directed full frame.
        set_directed();
        rx_q.delete();
        d0 = done_cnt;
        pulse_start();
        check("meas_en_after_start", meas_en, 1);
        wait_done(2000, "full_frame");
        check("full_len", rx_q.size(), FRAME_BYTES);
        check("full_b0",  rx_q[0],  8'hA5);
        check("full_b4",  rx_q[4],  8'h12);
        check("full_b5",  rx_q[5],  8'h1F);
        check("full_b6",  rx_q[6],  8'hFF);
        check("full_b12", rx_q[12], 8'h00);
`ifdef FRAME_CHECKSUM_EN
        check("full_csum", rx_q[13], 8'hF2);
`endif
        check("full_done_cnt", done_cnt - d0, 1);
        tick(3);

        // Backpressure on byte 2.
        rx_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_rx(2, 2000, "bp_reach_byte2");
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp_valid_held", tx_bus.tx_valid, 1);
            check("bp_data_held",  tx_bus.tx_data, 8'h00);
        end
        tx_ready = 1'b1;
        wait_done(2000, "bp_frame");
        check("bp_len",  rx_q.size(), FRAME_BYTES);
        check("bp_b3",   rx_q[3], 8'h00);
        check("bp_b4",   rx_q[4], 8'h12);
        check("bp_done_cnt", done_cnt - d0, 1);
        tick(3);

        // Continuous mode: two back-to-back frames.
        rx_q.delete();
        d0 = done_cnt;
        cont = 1'b1;
        pulse_start();
        wait_done(2000, "cont_frame1");
        cont = 1'b0;
        wait_done(2000, "cont_frame2");
        check("cont_len", rx_q.size(), 2 * FRAME_BYTES);
        check("cont_second_hdr", rx_q[FRAME_BYTES], 8'hA5);
        check("cont_done_cnt", done_cnt - d0, 2);
        tick(3);

        // Abort during ch1 bytes.
        rx_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_rx(7, 2000, "abort_reach_ch1");
        rst = 1'b1;
        tx_ready = 1'b0;
        tick(1);
        check("abort_tx_valid", tx_bus.tx_valid, 0);
        check("abort_meas_en",  meas_en, 0);
        check("abort_busy",     busy, 0);
        rst = 1'b0;
        tx_ready = 1'b1;
        tick(5);
        check("abort_no_resume", busy, 0);
        check("abort_done_cnt", done_cnt - d0, 0);

        // Start pulses while busy do not disturb the frame.
        rx_q.delete();
        d0 = done_cnt;
        pulse_start();
        tick(40);
        pulse_start();
        wait_rx(4, 2000, "busy_reach_send");
        pulse_start();
        wait_done(2000, "busy_start_frame");
        tick(5);
        check("busy_start_len", rx_q.size(), FRAME_BYTES);
        check("busy_start_idle", busy, 0);
        check("busy_start_done_cnt", done_cnt - d0, 1);

        // Randomised frames with random backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < NUM_CH; c++) ch_val[c] = BIT_CNT'($urandom);
            rx_q.delete();
            d0 = done_cnt;
            pulse_start();
            wait_done(3000, "rand_frame");
            check("rand_len", rx_q.size(), FRAME_BYTES);
            check("rand_done_cnt", done_cnt - d0, 1);
            tick($urandom_range(1, 5));
        end
        rand_ready = 1'b0;
        tx_ready = 1'b1;
        tick(2);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
